// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N:1 packet stream multiplexer.
package stream_mux_pkg;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/stream_mux_n_1_rr_arb.sv
// Combinational arbiter: round-robin from ptr (RR=1) or lowest index first (RR=0).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int RR   = 1,
  localparam int CH_W = ch_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  logic [2*N-1:0] dbl_req;

  // Lower copy masked below ptr, upper copy unmasked: the lowest set bit of
  // the doubled vector is the first requester at or after ptr, with wrap.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dbl_req   = {req, req};
    gnt_valid = |req;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (RR != 0 && i < int'(ptr)) dbl_req[i] = 1'b0;
    end
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (dbl_req[j]) gnt_idx = CH_W'(j % N);
    end
  end

endmodule

// File: rtl/stream_mux_n_1_rr.sv
// Clocked N:1 stream mux with packet-locked arbitration and one registered output stage.
module stream_mux_n_1_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int WIDTH = 8,
  parameter  int RR    = 1,
  localparam int CH_W  = ch_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN-1:0]       in_last,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  lock_state_e      state_q, state_d;
  logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;

  logic             arb_valid;
  logic [CH_W-1:0]  arb_idx;
  logic [CH_W-1:0]  grant_idx;
  logic [N_IN-1:0]  gnt_oh;
  logic             grant_present;
  logic             load_en;
  logic             accept;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N_IN), .RR(RR)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // While locked the arbiter is ignored; a stalled owner simply yields no grant.
  always_comb begin
    grant_idx = (state_q == LOCKED) ? lock_ch_q : arb_idx;
    for (int i = 0; i < N_IN; i++) begin
      gnt_oh[i] = (grant_idx == CH_W'(i)) & in_valid[i];
    end
    grant_present = (state_q == LOCKED) ? |gnt_oh : arb_valid;
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_oh[i]}});
      sel_last = sel_last | (in_last[i] & gnt_oh[i]);
    end
  end

  assign load_en  = ~out_valid_q | out_ready;
  assign accept   = grant_present & load_en;
  assign in_ready = gnt_oh & {N_IN{load_en}};

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_last_d  = sel_last;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      if (sel_last) begin
        state_d = UNLOCKED;
        if (RR != 0) begin
          ptr_d = (grant_idx == CH_W'(N_IN - 1)) ? '0 : grant_idx + CH_W'(1);
        end
      end else begin
        state_d   = LOCKED;
        lock_ch_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n_1_rr.sv
// Directed bench: round-robin, packet lock, back-pressure, stall, reset, RR=0 and N_IN=1.
module tb_stream_mux_n_1_rr;

  logic clk;
  logic rst_n;

  logic [3:0]  valid, last, ready;
  logic [31:0] data;
  logic        ov, ol, out_ready;
  logic [7:0]  od;
  logic [1:0]  och;

  logic [3:0]  r0_valid, r0_last, r0_ready;
  logic [31:0] r0_data;
  logic        r0_ov, r0_ol;
  logic [7:0]  r0_od;
  logic [1:0]  r0_och;

  logic        n1_valid, n1_last, n1_ready;
  logic [7:0]  n1_data;
  logic        n1_ov, n1_ol;
  logic [7:0]  n1_od;
  logic [0:0]  n1_och;

  int errors = 0;
  int checks = 0;

  stream_mux_n_1_rr #(.N_IN(4), .WIDTH(8), .RR(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid), .in_last(last), .in_data(data),
    .in_ready(ready), .out_valid(ov), .out_last(ol), .out_data(od), .out_ch(och),
    .out_ready(out_ready)
  );

  stream_mux_n_1_rr #(.N_IN(4), .WIDTH(8), .RR(0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .in_valid(r0_valid), .in_last(r0_last), .in_data(r0_data),
    .in_ready(r0_ready), .out_valid(r0_ov), .out_last(r0_ol), .out_data(r0_od),
    .out_ch(r0_och), .out_ready(1'b1)
  );

  stream_mux_n_1_rr #(.N_IN(1), .WIDTH(8), .RR(1)) u_single (
    .clk(clk), .rst_n(rst_n), .in_valid(n1_valid), .in_last(n1_last), .in_data(n1_data),
    .in_ready(n1_ready), .out_valid(n1_ov), .out_last(n1_ol), .out_data(n1_od),
    .out_ch(n1_och), .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    valid = '0; last = '0; data = '0;
    r0_valid = '0; r0_last = '0; r0_data = '0;
    n1_valid = 1'b0; n1_last = 1'b0; n1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", ov, 0);
    check("rst_ol", ol, 0);
    check("rst_od", od, 0);
    check("rst_och", och, 0);
    rst_n = 1'b1;
    step();
    check("idle_ready", ready, 4'b0000);

    // Round-robin single beats
    valid = 4'b1111; last = 4'b1111; data = {8'h33, 8'h22, 8'h11, 8'h00};
    settle();
    check("rr_first_ready", ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_ov", ov, 1);
      check("rr_och", och, k % 4);
      check("rr_od", od, (k % 4) * 8'h11);
    end
    valid = '0;
    step();
    check("rr_drain", ov, 0);

    // Packet lock on ch1 (ptr=1) with ch2 waiting
    valid = 4'b0110; last = 4'b0100; data = {8'h00, 8'hB1, 8'hA1, 8'h00};
    settle();
    check("lock_ready_a1", ready, 4'b0010);
    step();
    check("lock_a1", od, 8'hA1);
    check("lock_a1_ch", och, 1);
    data[15:8] = 8'hA2;
    settle();
    check("lock_ready_a2", ready, 4'b0010);
    step();
    check("lock_a2", od, 8'hA2);
    data[15:8] = 8'hA3; last = 4'b0110;
    settle();
    check("lock_ready_a3", ready, 4'b0010);
    step();
    check("lock_a3", od, 8'hA3);
    check("lock_a3_last", ol, 1);
    valid = 4'b0100;
    settle();
    check("lock_ready_b1", ready, 4'b0100);
    step();
    check("lock_b1", od, 8'hB1);
    check("lock_b1_ch", och, 2);
    valid = '0;
    step();
    check("lock_drain", ov, 0);

    // Back-pressure (ptr=3)
    valid = 4'b1000; last = 4'b1000; data = {8'h3C, 8'h00, 8'h00, 8'h00}; out_ready = 1'b0;
    settle();
    check("bp_ready_load", ready, 4'b1000);
    step();
    check("bp_od", od, 8'h3C);
    valid = 4'b0001; last = 4'b0001; data = {8'h00, 8'h00, 8'h00, 8'h0D};
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_ready_stall", ready, 4'b0000);
      check("bp_hold_ov", ov, 1);
      check("bp_hold_od", od, 8'h3C);
      check("bp_hold_och", och, 3);
      step();
    end
    out_ready = 1'b1;
    settle();
    check("bp_ready_release", ready, 4'b0001);
    step();
    check("bp_next_od", od, 8'h0D);
    check("bp_next_och", och, 0);
    check("bp_next_ov", ov, 1);
    valid = '0;
    step();
    check("bp_drain", ov, 0);

    // Locked stall: ch0 pauses mid-packet while ch3 waits (ptr=1)
    valid = 4'b0001; last = 4'b0000; data = {8'h00, 8'h00, 8'h00, 8'hC1};
    settle();
    check("stall_ready_c1", ready, 4'b0001);
    step();
    check("stall_c1", od, 8'hC1);
    valid = 4'b1000; last = 4'b1000; data = {8'hD3, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      settle();
      check("stall_ready_none", ready, 4'b0000);
      step();
      check("stall_ov", ov, 0);
    end
    valid = 4'b1001; last = 4'b1001; data = {8'hD3, 8'h00, 8'h00, 8'hC2};
    settle();
    check("stall_ready_c2", ready, 4'b0001);
    step();
    check("stall_c2", od, 8'hC2);
    check("stall_c2_ch", och, 0);
    settle();
    check("stall_ptr1_ready", ready, 4'b1000);
    step();
    check("stall_d3", od, 8'hD3);
    check("stall_d3_ch", och, 3);
    valid = '0;
    step();
    check("stall_drain", ov, 0);

    // Reset mid-packet with a held beat (ptr=0)
    valid = 4'b0010; last = 4'b0010; data = {8'h00, 8'h00, 8'h5A, 8'h00};
    step();
    check("mid_single_ch", och, 1);
    valid = 4'b0100; last = 4'b0000; data = {8'h00, 8'h77, 8'h00, 8'h00};
    settle();
    check("mid_ready", ready, 4'b0100);
    step();
    check("mid_held_od", od, 8'h77);
    check("mid_held_och", och, 2);
    out_ready = 1'b0;
    settle();
    rst_n = 1'b0;
    settle();
    check("mid_rst_ov", ov, 0);
    check("mid_rst_od", od, 0);
    check("mid_rst_och", och, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1; valid = '0;
    settle();
    check("mid_rel_ready", ready, 4'b0000);
    valid = 4'b1010; last = 4'b1010; data = {8'h63, 8'h00, 8'h61, 8'h00};
    settle();
    check("mid_restart_ready", ready, 4'b0010);
    step();
    check("mid_restart_od", od, 8'h61);
    valid = '0;

    // Fixed priority: ch1 always wins over ch3
    r0_valid = 4'b1010; r0_last = 4'b1111; r0_data = {8'h33, 8'h22, 8'h11, 8'h00};
    settle();
    check("fp_ready", r0_ready, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fp_och", r0_och, 1);
      check("fp_od", r0_od, 8'h11);
    end
    r0_valid = '0;

    // Single channel: every beat passes, packets of two beats
    n1_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n1_data = 8'(k * 3);
      n1_last = (k % 2 == 0);
      settle();
      check("n1_ready", n1_ready, 1);
      step();
      check("n1_ov", n1_ov, 1);
      check("n1_od", n1_od, k * 3);
      check("n1_och", n1_och, 0);
      check("n1_ol", n1_ol, (k % 2 == 0));
    end
    n1_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
